// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one registered bitwise logic unit
// between N_REQ valid/ready requesters, returning results on one valid/ready channel.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int W = 8,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    output logic [N_REQ-1:0]   o_req_ready,
    input  logic [3*N_REQ-1:0] i_req_op,
    input  logic [W*N_REQ-1:0] i_req_a,
    input  logic [W*N_REQ-1:0] i_req_b,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [IDW-1:0]     o_rsp_id,
    output logic [W-1:0]       o_rsp_y,
    output logic               o_rsp_err
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t r_state;
    logic [IDW-1:0] r_ptr, r_id, w_gidx, w_idx;
    logic [W-1:0] r_y, w_a, w_b, w_y;
    logic r_err, w_err, w_found, w_accept, w_xfer;
    logic [2:0] w_op;
    logic [N_REQ-1:0] w_grant;
    logic [2:0] w_ops [N_REQ];
    logic [W-1:0] w_as [N_REQ];
    logic [W-1:0] w_bs [N_REQ];
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_ops[i] = i_req_op[3*i +: 3];
            w_as[i] = i_req_a[W*i +: W];
            w_bs[i] = i_req_b[W*i +: W];
        end
    end
    // search starts one past the last winner so the previous owner has lowest priority
    always_comb begin
        w_grant = '0;
        w_gidx = '0;
        w_idx = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
    end
    assign w_accept = (r_state == EMPTY) || i_rsp_ready;
    assign o_req_ready = (w_found && w_accept && rst_n) ? w_grant : '0;
    assign w_xfer = |o_req_ready;
    assign w_op = w_ops[w_gidx];
    assign w_a = w_as[w_gidx];
    assign w_b = w_bs[w_gidx];
    assign w_err = w_op[2] & w_op[1];
    assign w_y = (w_op == 3'd0) ? (w_a & w_b) :
                 (w_op == 3'd1) ? ~(w_a & w_b) :
                 (w_op == 3'd2) ? ~(w_a | w_b) :
                 (w_op == 3'd3) ? (w_a | w_b) :
                 (w_op == 3'd4) ? ~(w_a ^ w_b) :
                 (w_op == 3'd5) ? (w_a ^ w_b) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr <= IDW'(N_REQ - 1);
            r_id <= '0;
            r_y <= '0;
            r_err <= 1'b0;
        end else if (w_xfer) begin
            r_state <= FULL;
            r_ptr <= w_gidx;
            r_id <= w_gidx;
            r_y <= w_y;
            r_err <= w_err;
        end else if (r_state == FULL && i_rsp_ready) begin
            r_state <= EMPTY;
        end
    end
    assign o_rsp_valid = (r_state == FULL);
    assign o_rsp_id = r_id;
    assign o_rsp_y = r_y;
    assign o_rsp_err = r_err;
endmodule
